// File: rtl/morse_key_sequencer_if.sv
`timescale 1ns/1ps
// Key-line and decoder-strobe bundle for morse_key_sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; the strobes are fire-and-forget, with no ready signal.
//
// Signals:
//   Key     raw key line, asynchronous, 1 = tone
//   Enable  1 = sequencing active
//   Dot/Dash/Lg/Wg  one-cycle classification strobes
//   Valid   level, 0 = stuck key (sticky)
//   Busy    sequencer not idle
// Modports:
//   master  drives Key/Enable and consumes the strobes (key source / bench)
//   slave   the sequencer itself
interface morse_key_sequencer_if;
  logic Key;
  logic Enable;
  logic Dot;
  logic Dash;
  logic Lg;
  logic Wg;
  logic Valid;
  logic Busy;

  modport master (
    output Key, Enable,
    input  Dot, Dash, Lg, Wg, Valid, Busy
  );

  modport slave (
    input  Key, Enable,
    output Dot, Dash, Lg, Wg, Valid, Busy
  );
endinterface

// File: rtl/morse_key_sequencer.sv
`timescale 1ns/1ps
// Turns a raw Morse key line into Dot/Dash/letter-gap/word-gap strobes for the decoder.
// Latency: Key edge to Dot/Dash is 3 cycles (3 + DEB_CYCLES with the debouncer).
// Backpressure: none; the strobes are one-cycle pulses and the consumer must take them.
//
// Ports:
//   clock  system clock, rising edge
//   Clr    asynchronous active-low reset
//   bus    morse_key_sequencer_if.slave (Key, Enable in; Dot, Dash, Lg, Wg, Valid, Busy out)
// Optional feature: define MORSE_DEBOUNCE_EN to insert a DEB_CYCLES stability filter
// after the synchronizer. When it is undefined, the filter is absent and DEB_CYCLES is unused.
module morse_key_sequencer #(
  parameter int UNIT_CYCLES = 4,
  parameter int PRE_W       = 8,
  parameter int DEB_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  Clr,
  morse_key_sequencer_if.slave  bus
);

  // Reject parameter sets the counters cannot represent.
  if (UNIT_CYCLES < 2 || PRE_W < 1 || (UNIT_CYCLES - 1) >= (1 << PRE_W) || DEB_CYCLES < 1)
  begin : g_bad_params
    $error("morse_key_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_LGAP  = 3'd3,
    S_STUCK = 3'd4
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  // The key path resets to 1. A key that is already held when Clr releases
  // then produces no rising edge, and only a fresh press starts a mark. A key
  // that is released at reset produces a harmless fall while in IDLE.
  logic r_sync1;
  logic r_sync2;
  logic w_key_s;
  logic w_key_d;

  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.Key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_s = r_sync2;

`ifdef MORSE_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_key_deb;

  // Count the consecutive cycles on which key_s disagrees with the filtered
  // level. Any agreement restarts the count, so pulses shorter than
  // DEB_CYCLES are never passed through.
  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_deb_cnt <= '0;
      r_key_deb <= 1'b1;
    end else if (w_key_s == r_key_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      r_key_deb <= w_key_s;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_key_d = r_key_deb;
`else
  assign w_key_d = w_key_s;
`endif

  logic r_key_prev;
  logic w_rise;
  logic w_fall;
  logic w_edge;

  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_key_prev <= 1'b1;
    end else begin
      r_key_prev <= w_key_d;
    end
  end

  assign w_rise = w_key_d & ~r_key_prev;
  assign w_fall = ~w_key_d & r_key_prev;
  assign w_edge = w_rise | w_fall;

  // ---------------------------------------------------------------------------
  // Unit timing
  // ---------------------------------------------------------------------------
  // The cycle that shows the edge is count 0 of the new interval. The register
  // therefore resumes at 1 afterwards, and a unit is exactly UNIT_CYCLES
  // cycles measured from the edge. On an edge cycle the tick is suppressed.
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_units;
  logic             w_tick;
  logic             w_reach2;
  logic             w_reach5;
  logic             w_reach7;

  assign w_tick = (r_pre == PRE_LAST) & ~w_edge;

  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_pre <= '0;
    end else if (!bus.Enable) begin
      r_pre <= '0;
    end else if (w_edge) begin
      r_pre <= PRE_W'(1);
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_units <= 3'd0;
    end else if (!bus.Enable || w_edge) begin
      r_units <= 3'd0;
    end else if (w_tick && (r_units != 3'd7)) begin
      r_units <= r_units + 3'd1;
    end
  end

  // "Units reach N" is the tick that moves the counter from N-1 to N. Acting
  // on it in that same cycle lines the registered strobe up with the counter.
  assign w_reach2 = w_tick & (r_units == 3'd1);
  assign w_reach5 = w_tick & (r_units == 3'd4);
  assign w_reach7 = w_tick & (r_units == 3'd6);

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   r_dot, r_dash, r_lg, r_wg, r_valid;
  logic   w_dot_nxt, w_dash_nxt, w_lg_nxt, w_wg_nxt, w_valid_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_dot_nxt   = 1'b0;
    w_dash_nxt  = 1'b0;
    w_lg_nxt    = 1'b0;
    w_wg_nxt    = 1'b0;
    w_valid_nxt = r_valid;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_MARK;
        end
      end
      S_MARK: begin
        // A fall with units 7 cannot occur: the stuck check fires first.
        if (w_fall) begin
          if (r_units < 3'd2) begin
            w_dot_nxt = 1'b1;
          end else begin
            w_dash_nxt = 1'b1;
          end
          w_state_nxt = S_SPACE;
        end else if (w_reach7) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_STUCK;
        end
      end
      S_SPACE: begin
        if (w_rise) begin
          w_state_nxt = S_MARK;
        end else if (w_reach2) begin
          w_lg_nxt    = 1'b1;
          w_state_nxt = S_LGAP;
        end
      end
      S_LGAP: begin
        if (w_rise) begin
          w_state_nxt = S_MARK;
        end else if (w_reach5) begin
          w_wg_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_STUCK: begin
        if (!w_key_d) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Disabling drops any interval in progress silently. A stuck flag that
    // was already raised is kept.
    if (!bus.Enable) begin
      w_state_nxt = S_IDLE;
      w_dot_nxt   = 1'b0;
      w_dash_nxt  = 1'b0;
      w_lg_nxt    = 1'b0;
      w_wg_nxt    = 1'b0;
      w_valid_nxt = r_valid;
    end
  end

  always_ff @(posedge clock or negedge Clr) begin
    if (!Clr) begin
      r_state <= S_IDLE;
      r_dot   <= 1'b0;
      r_dash  <= 1'b0;
      r_lg    <= 1'b0;
      r_wg    <= 1'b0;
      r_valid <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_dot   <= w_dot_nxt;
      r_dash  <= w_dash_nxt;
      r_lg    <= w_lg_nxt;
      r_wg    <= w_wg_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.Dot   = r_dot;
  assign bus.Dash  = r_dash;
  assign bus.Lg    = r_lg;
  assign bus.Wg    = r_wg;
  assign bus.Valid = r_valid;
  assign bus.Busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
`timescale 1ns/1ps
// Bench for morse_key_sequencer: a table of marks and gaps, plus hand sequences for stuck key, reset and enable.
// Latency: strobe times are predicted from Key drive cycles (mark +3, Lg +10, Wg +22, plus the debounce offset).
// Backpressure: none; a negedge monitor pops the expected-strobe queue as the strobes appear.
module tb_morse_key_sequencer;

  localparam int UNIT = 4;
  localparam int DEB  = 2;
`ifdef MORSE_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 0;
`endif

  localparam int K_DOT  = 1;
  localparam int K_DASH = 2;
  localparam int K_LG   = 3;
  localparam int K_WG   = 4;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  typedef struct {
    int hi;
    int lo;
    int mark;
    bit lg;
    bit wg;
  } vec_t;

  logic clock = 1'b0;
  logic Clr;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];
  vec_t vecs[12];

  morse_key_sequencer_if u_if();

  morse_key_sequencer #(
    .UNIT_CYCLES (UNIT),
    .PRE_W       (8),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clock (clock),
    .Clr   (Clr),
    .bus   (u_if)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    u_if.Key = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard monitor: every strobe must be the next expected event, at its predicted cycle.
  ev_t m_e;
  int  m_n;
  int  m_kind;
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      m_e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_strobe: kind %0d expected at cycle %0d, not seen by cycle %0d",
               m_e.kind, m_e.at, cyc);
    end
    m_n = int'(u_if.Dot) + int'(u_if.Dash) + int'(u_if.Lg) + int'(u_if.Wg);
    if (m_n != 0) begin
      check("strobe_one_hot", m_n, 1);
      m_kind = u_if.Dot ? K_DOT : (u_if.Dash ? K_DASH : (u_if.Lg ? K_LG : K_WG));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", m_kind, cyc);
      end else begin
        m_e = exp_q.pop_front();
        check("strobe_kind", m_kind, m_e.kind);
        check("strobe_cycle", cyc, m_e.at);
      end
    end
  end

  initial begin
    int f;
    int r;

    //          hi  lo  mark    lg  wg
    vecs[0]  = '{4,  40, K_DOT,  1'b1, 1'b1};
    vecs[1]  = '{12, 40, K_DASH, 1'b1, 1'b1};
    vecs[2]  = '{7,  30, K_DOT,  1'b1, 1'b1};   // longest dot
    vecs[3]  = '{8,  30, K_DASH, 1'b1, 1'b1};   // shortest dash
    vecs[4]  = '{27, 30, K_DASH, 1'b1, 1'b1};   // longest dash
    vecs[5]  = '{1,  40, K_DOT,  1'b1, 1'b1};   // one-cycle glitch
    vecs[6]  = '{4,  7,  K_DOT,  1'b0, 1'b0};   // gap one cycle short of Lg
    vecs[7]  = '{4,  8,  K_DOT,  1'b1, 1'b0};   // shortest gap giving Lg
    vecs[8]  = '{12, 19, K_DASH, 1'b1, 1'b0};   // gap one cycle short of Wg
    vecs[9]  = '{4,  20, K_DOT,  1'b1, 1'b1};   // shortest gap giving Wg
    vecs[10] = '{4,  4,  K_DOT,  1'b0, 1'b0};   // letter ".-" ...
    vecs[11] = '{12, 40, K_DASH, 1'b1, 1'b1};   // ... its dash

    Clr         = 1'b0;
    u_if.Key    = 1'b0;
    u_if.Enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_dot",   u_if.Dot,   0);
    check("reset_dash",  u_if.Dash,  0);
    check("reset_lg",    u_if.Lg,    0);
    check("reset_wg",    u_if.Wg,    0);
    check("reset_busy",  u_if.Busy,  0);
    check("reset_valid", u_if.Valid, 1);
    Clr = 1'b1;
    hold(1'b0, 10);

    // Table of marks and gaps
    for (int i = 0; i < 12; i++) begin
      hold(1'b1, vecs[i].hi);
      f = cyc;
      if (!(D > 0 && vecs[i].hi < DEB)) begin
        push(vecs[i].mark, f + 3 + D);
        if (vecs[i].lg) push(K_LG, f + 10 + D);
        if (vecs[i].wg) push(K_WG, f + 22 + D);
      end
      hold(1'b0, vecs[i].lo);
    end

    // Busy window around a single dot
    r = cyc;
    u_if.Key = 1'b1;
    wait_to(r + 2 + D);
    check("busy_before_rise", u_if.Busy, 0);
    wait_to(r + 3 + D);
    check("busy_in_mark", u_if.Busy, 1);
    wait_to(r + 4);
    u_if.Key = 1'b0;
    f = cyc;
    push(K_DOT, f + 3 + D);
    push(K_LG,  f + 10 + D);
    push(K_WG,  f + 22 + D);
    wait_to(f + 21 + D);
    check("busy_before_wg", u_if.Busy, 1);
    wait_to(f + 22 + D);
    check("busy_after_wg", u_if.Busy, 0);
    wait_to(f + 40);

    // Stuck key: Valid drops as units reach 7 and stays low until Clr
    r = cyc;
    u_if.Key = 1'b1;
    wait_to(r + 29 + D);
    check("valid_before_stuck", u_if.Valid, 1);
    wait_to(r + 30 + D);
    check("valid_stuck", u_if.Valid, 0);
    check("busy_stuck", u_if.Busy, 1);
    wait_to(r + 40);
    u_if.Key = 1'b0;
    f = cyc;
    wait_to(f + 30);
    check("valid_sticky", u_if.Valid, 0);
    check("busy_after_stuck", u_if.Busy, 0);
    Clr = 1'b0;
    #1;
    check("valid_after_clr", u_if.Valid, 1);
    hold(1'b0, 2);
    Clr = 1'b1;
    hold(1'b0, 10);

    // Reset in the middle of a mark: everything clears, no strobe after release
    r = cyc;
    u_if.Key = 1'b1;
    wait_to(r + 3 + D);
    check("busy_before_clr", u_if.Busy, 1);
    Clr = 1'b0;
    #1;
    check("clr_mid_busy",  u_if.Busy,  0);
    check("clr_mid_valid", u_if.Valid, 1);
    check("clr_mid_dot",   u_if.Dot,   0);
    check("clr_mid_dash",  u_if.Dash,  0);
    wait_to(r + 5 + D);
    Clr = 1'b1;
    wait_to(r + 6 + D);
    u_if.Key = 1'b0;
    f = cyc;
    wait_to(f + 40);
    check("busy_after_clr_mark", u_if.Busy, 0);

    // Enable dropped mid-mark: mark discarded, Valid untouched
    r = cyc;
    u_if.Key = 1'b1;
    wait_to(r + 3 + D);
    check("busy_before_disable", u_if.Busy, 1);
    u_if.Enable = 1'b0;
    wait_to(r + 5 + D);
    check("busy_disabled", u_if.Busy, 0);
    u_if.Enable = 1'b1;
    wait_to(r + 8 + D);
    u_if.Key = 1'b0;
    f = cyc;
    wait_to(f + 40);
    check("busy_after_enable", u_if.Busy, 0);
    check("valid_after_enable", u_if.Valid, 1);

    hold(1'b0, 10);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
